// File: rtl/dsp_multacc_lanes.sv
// Multi-lane multiply-accumulate pipeline: S1 input register, S2 multiply, S3 accumulate, output shift/round/reduce.
// Define DSP_MULTACC_SATURATE_EN to clamp outputs to the Z_WIDTH range instead of wrapping.
module dsp_multacc_lanes #(
  parameter int LANES     = 2,
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 9,
  parameter int ACC_WIDTH = 24,
  parameter int Z_WIDTH   = 19
) (
  input  logic                       clk,
  input  logic                       lreset,
  input  logic                       in_valid,
  input  logic [LANES*A_WIDTH-1:0]   a,
  input  logic [LANES*B_WIDTH-1:0]   b,
  input  logic                       unsigned_a,
  input  logic                       unsigned_b,
  input  logic                       acc_clear,
  input  logic                       subtract,
  input  logic [4:0]                 shift_right,
  input  logic                       round,
  output logic                       out_valid,
  output logic [LANES*Z_WIDTH-1:0]   z,
  output logic [LANES-1:0]           out_sat
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH + 2;

  logic                     v1, v2, v3, ov;
  logic [LANES*A_WIDTH-1:0] a1;
  logic [LANES*B_WIDTH-1:0] b1;
  logic                     ua1, ub1, clr1, sub1, rnd1;
  logic [4:0]               shr1;
  logic                     sgn2, clr2, sub2, rnd2;
  logic [4:0]               shr2;
  logic                     sgn3, rnd3;
  logic [4:0]               shr3;
  logic [4:0]               sh_amt;

  // Controls ride alongside their sample so each stage sees the sample's own settings.
  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; ov <= 1'b0;
      a1 <= '0; b1 <= '0;
      ua1 <= 1'b0; ub1 <= 1'b0; clr1 <= 1'b0; sub1 <= 1'b0; rnd1 <= 1'b0; shr1 <= '0;
      sgn2 <= 1'b0; clr2 <= 1'b0; sub2 <= 1'b0; rnd2 <= 1'b0; shr2 <= '0;
      sgn3 <= 1'b0; rnd3 <= 1'b0; shr3 <= '0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      ov <= v3;
      if (in_valid) begin
        a1 <= a; b1 <= b;
        ua1 <= unsigned_a; ub1 <= unsigned_b;
        clr1 <= acc_clear; sub1 <= subtract;
        shr1 <= shift_right; rnd1 <= round;
      end
      if (v1) begin
        sgn2 <= ~(ua1 & ub1);
        clr2 <= clr1; sub2 <= sub1;
        shr2 <= shr1; rnd2 <= rnd1;
      end
      if (v2) begin
        sgn3 <= sgn2; shr3 <= shr2; rnd3 <= rnd2;
      end
    end
  end

  assign out_valid = ov;

  always_comb begin
    sh_amt = (32'(shr3) > ACC_WIDTH - 1) ? 5'(ACC_WIDTH - 1) : shr3;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [A_WIDTH:0]   ax;
    logic signed [B_WIDTH:0]   bx;
    logic signed [P_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]      p2, acc;
    logic signed [ACC_WIDTH:0] acc_x, rnd_add;
    logic [Z_WIDTH-1:0]        z_next, z_q;

    // One extra bit per operand lets a single signed multiply cover every signedness mix exactly.
    always_comb begin
      ax   = {~ua1 & a1[l*A_WIDTH + A_WIDTH - 1], a1[l*A_WIDTH +: A_WIDTH]};
      bx   = {~ub1 & b1[l*B_WIDTH + B_WIDTH - 1], b1[l*B_WIDTH +: B_WIDTH]};
      prod = ax * bx;
    end

    // The extra top bit makes >>> behave as a logical shift for unsigned samples.
    always_comb begin
      acc_x   = sgn3 ? $signed({acc[ACC_WIDTH-1], acc}) : $signed({1'b0, acc});
      rnd_add = '0;
      if (rnd3 && sh_amt != '0) rnd_add[0] = acc[sh_amt - 5'd1];
    end

`ifdef DSP_MULTACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] ZMAX_S = {{(ACC_WIDTH-Z_WIDTH+2){1'b0}}, {(Z_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ZMIN_S = {{(ACC_WIDTH-Z_WIDTH+2){1'b1}}, {(Z_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] ZMAX_U = {{(ACC_WIDTH-Z_WIDTH+1){1'b0}}, {Z_WIDTH{1'b1}}};
    logic signed [ACC_WIDTH:0] sh_x;
    logic                      sat_next, sat_q;

    always_comb begin
      sh_x     = (acc_x >>> sh_amt) + rnd_add;
      z_next   = sh_x[Z_WIDTH-1:0];
      sat_next = 1'b0;
      if (sgn3) begin
        if (sh_x > ZMAX_S) begin
          z_next = ZMAX_S[Z_WIDTH-1:0]; sat_next = 1'b1;
        end else if (sh_x < ZMIN_S) begin
          z_next = ZMIN_S[Z_WIDTH-1:0]; sat_next = 1'b1;
        end
      end else if (sh_x > ZMAX_U) begin
        z_next = ZMAX_U[Z_WIDTH-1:0]; sat_next = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge lreset) begin
      if (lreset)  sat_q <= 1'b0;
      else if (v3) sat_q <= sat_next;
    end

    assign out_sat[l] = sat_q;
`else
    always_comb begin
      z_next = Z_WIDTH'((acc_x >>> sh_amt) + rnd_add);
    end

    assign out_sat[l] = 1'b0;
`endif

    always_ff @(posedge clk or posedge lreset) begin
      if (lreset) begin
        p2  <= '0;
        acc <= '0;
        z_q <= '0;
      end else begin
        if (v1) p2  <= ACC_WIDTH'(prod);
        if (v2) acc <= (clr2 ? '0 : acc) + (sub2 ? -p2 : p2);
        if (v3) z_q <= z_next;
      end
    end

    assign z[l*Z_WIDTH +: Z_WIDTH] = z_q;
  end

endmodule
